connect4_turn_ctrl: RTL
=======================

CONNECT4_TURN_CTRL -- requirements
Module: connect4_turn_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000, number of idle cycles before a turn is forfeited (used only with MOVE_TIMEOUT_EN).
REQ-002 Parameter FIRST_P2, default 0, 1 = player 2 moves first after reset.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 col_n  input  4  column select switches, active-low one-hot; bit i low = column i.
REQ-006 btn_n  input  1  drop button, active-low, synchronous to clk.
REQ-007 chk_done  input  1  external win checker done strobe, one cycle.
REQ-008 chk_win  input  1  win result, valid with chk_done; 1 = current player has four in line.
REQ-009 chk_req  output  1  one-cycle request to the win checker.
REQ-010 gameboard  output  16  occupancy; bit row*4+col = 1 if the cell is filled; row 0 = bottom.
REQ-011 player_moves  output  16  ownership; bit = 1 if player 1 owns the cell, 0 if player 2 owns it or the cell is empty.
REQ-012 cur_player  output  1  0 = P1 to move, 1 = P2 to move.
REQ-013 game_over  output  1  high from game end until reset.
REQ-014 winner  output  2  00 none, 01 P1, 10 P2, 11 tie.
REQ-015 move_err  output  1  one-cycle pulse on a rejected move.

Function
REQ-016 FSM states SHALL be IDLE, DECODE, WRITE, CHECK, NEXT, OVER.
REQ-017 Button event = btn_n sampled 0 with previous sample 1; events are acted on only in IDLE and ignored in every other state.
REQ-018 IDLE -> DECODE on a button event; col_n SHALL be latched on the same edge.
REQ-019 DECODE: latched col_n with other than exactly one zero bit, or a target column with all 4 rows filled, SHALL pulse move_err and return to IDLE with the board and player unchanged.
REQ-020 DECODE: the target row SHALL be the lowest empty row of the column.
REQ-021 WRITE: set the gameboard bit and the player_moves bit (= ~cur_player); the board updates 2 clocks after the edge that detects the button event.
REQ-022 CHECK: assert chk_req for exactly the first cycle, then wait any number of cycles for chk_done.
REQ-023 On chk_done with chk_win=1, go to OVER with winner = 01 if cur_player=0, or 10 if cur_player=1.
REQ-024 On chk_done with chk_win=0 and gameboard = 16'hFFFF, go to OVER with winner = 11.
REQ-025 Otherwise go to NEXT, toggle cur_player, then return to IDLE.
REQ-026 OVER: game_over=1; the board, winner and cur_player are frozen; button events are ignored.
REQ-027 If chk_done arrives outside CHECK, it SHALL be ignored.

Reset
REQ-028 When reset=0 at a clock edge, the state SHALL become IDLE, regardless of the current state (including CHECK).
REQ-029 The same reset SHALL set gameboard=0, player_moves=0, winner=00, game_over=0, chk_req=0, move_err=0, cur_player=FIRST_P2, button history=1, and the timeout counter to 0.

Configuration
REQ-030 Macro MOVE_TIMEOUT_EN defined: a counter increments every cycle in IDLE and clears on every button event and every state exit.
REQ-031 When the counter reaches TIMEOUT_CYCLES-1, cur_player SHALL toggle, move_err SHALL pulse once, and the counter SHALL clear.
REQ-032 A button event in the same cycle as the timeout SHALL take priority, and no forfeit occurs.
REQ-033 Macro undefined: no counter logic, and turns never expire.

Verification
REQ-034 Reset, then col_n=1110 with one button press -> gameboard=0x0001, player_moves=0x0001, chk_req pulse; after chk_done with chk_win=0 -> cur_player=1.
REQ-035 Sequence P1 col0, P2 col1, P1 col0 with chk_win=0 -> gameboard=0x0013, player_moves=0x0011.
REQ-036 Five presses on col0 -> the fifth press pulses move_err and gameboard stays 0x1111; col_n=1100 -> move_err and no board change.
REQ-037 chk_done with chk_win=1 while cur_player=0 -> winner=01 and game_over=1; a further press leaves the board unchanged; reset low for one cycle -> all outputs at reset values.
REQ-038 Fill all 16 cells with chk_win=0 -> winner=11 and game_over=1.
REQ-039 With MOVE_TIMEOUT_EN and TIMEOUT_CYCLES=8, no press for 8 cycles -> cur_player toggles and move_err pulses once.

Source files
------------

// File: rtl/connect4_turn_ctrl_if.sv
// rtl/connect4_turn_ctrl_if.sv - player inputs, win-checker handshake and game-state outputs
interface connect4_turn_ctrl_if;
  logic [3:0]  col_n;
  logic        btn_n;
  logic        chk_done;
  logic        chk_win;
  logic        chk_req;
  logic [15:0] gameboard;
  logic [15:0] player_moves;
  logic        cur_player;
  logic        game_over;
  logic [1:0]  winner;
  logic        move_err;

  // Driver side: supplies switches, button and checker results
  modport master (
    output col_n, btn_n, chk_done, chk_win,
    input  chk_req, gameboard, player_moves, cur_player, game_over, winner, move_err
  );

  // Controller side
  modport slave (
    input  col_n, btn_n, chk_done, chk_win,
    output chk_req, gameboard, player_moves, cur_player, game_over, winner, move_err
  );
endinterface

// File: rtl/connect4_turn_ctrl.sv
// rtl/connect4_turn_ctrl.sv - 4x4 connect-four turn controller; optional turn forfeit via MOVE_TIMEOUT_EN
module connect4_turn_ctrl #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter bit FIRST_P2       = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  connect4_turn_ctrl_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DECODE, WRITE, CHECK, NEXT, OVER} state_t;

  state_t      state, state_nxt;
  logic        btn_prev;
  logic        btn_evt;
  logic [3:0]  col_lat;
  logic [15:0] board;
  logic [15:0] owner;
  logic        player;
  logic [1:0]  win_r;
  logic        over_r;
  logic        req_r;
  logic        err_r;

  logic        col_ok;
  logic [1:0]  col_idx;
  logic [3:0]  col_bits;
  logic        col_full;
  logic [1:0]  row_idx;
  logic [3:0]  tgt_idx;

  logic        latch_col;
  logic        write_en;
  logic        toggle;
  logic        set_win;
  logic [1:0]  win_val;
  logic        req_now;
  logic        err_now;
  logic        timeout_hit;

  // A press is a 1 -> 0 transition of the button sample
  assign btn_evt = btn_prev & ~bus.btn_n;

  // Decode the latched column and find the lowest free row in it
  always_comb begin
    col_ok  = 1'b1;
    col_idx = 2'd0;
    case (~col_lat)
      4'b0001: col_idx = 2'd0;
      4'b0010: col_idx = 2'd1;
      4'b0100: col_idx = 2'd2;
      4'b1000: col_idx = 2'd3;
      default: col_ok  = 1'b0;
    endcase
    col_bits = {board[{2'd3, col_idx}], board[{2'd2, col_idx}],
                board[{2'd1, col_idx}], board[{2'd0, col_idx}]};
    col_full = &col_bits;
    if (!col_bits[0])      row_idx = 2'd0;
    else if (!col_bits[1]) row_idx = 2'd1;
    else if (!col_bits[2]) row_idx = 2'd2;
    else                   row_idx = 2'd3;
    tgt_idx = {row_idx, col_idx};
  end

`ifdef MOVE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt;

  assign timeout_hit = (state == IDLE) && !btn_evt && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter; restarts on a press, a forfeit or leaving IDLE
  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo_cnt <= '0;
    end else if (state != IDLE || btn_evt || timeout_hit) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo  = (TIMEOUT_CYCLES == 0);
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_nxt = state;
    latch_col = 1'b0;
    write_en  = 1'b0;
    toggle    = 1'b0;
    set_win   = 1'b0;
    win_val   = 2'b00;
    req_now   = 1'b0;
    err_now   = 1'b0;
    case (state)
      IDLE: begin
        if (btn_evt) begin
          latch_col = 1'b1;
          state_nxt = DECODE;
        end else if (timeout_hit) begin
          toggle  = 1'b1;
          err_now = 1'b1;
        end
      end
      DECODE: begin
        if (!col_ok || col_full) begin
          err_now   = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        write_en  = 1'b1;
        req_now   = 1'b1;
        state_nxt = CHECK;
      end
      CHECK: begin
        if (bus.chk_done) begin
          if (bus.chk_win) begin
            set_win   = 1'b1;
            win_val   = player ? 2'b10 : 2'b01;
            state_nxt = OVER;
          end else if (board == 16'hFFFF) begin
            set_win   = 1'b1;
            win_val   = 2'b11;
            state_nxt = OVER;
          end else begin
            state_nxt = NEXT;
          end
        end
      end
      NEXT: begin
        toggle    = 1'b1;
        state_nxt = IDLE;
      end
      OVER:    state_nxt = OVER;
      default: state_nxt = IDLE;
    endcase
  end

  // Board, turn, result and one-cycle pulse registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_prev <= 1'b1;
      col_lat  <= 4'hF;
      board    <= '0;
      owner    <= '0;
      player   <= FIRST_P2;
      win_r    <= 2'b00;
      over_r   <= 1'b0;
      req_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      btn_prev <= bus.btn_n;
      if (latch_col) col_lat <= bus.col_n;
      if (write_en) begin
        board[tgt_idx] <= 1'b1;
        owner[tgt_idx] <= ~player;
      end
      if (toggle) player <= ~player;
      if (set_win) begin
        win_r  <= win_val;
        over_r <= 1'b1;
      end
      req_r <= req_now;
      err_r <= err_now;
    end
  end

  assign bus.chk_req      = req_r;
  assign bus.gameboard    = board;
  assign bus.player_moves = owner;
  assign bus.cur_player   = player;
  assign bus.game_over    = over_r;
  assign bus.winner       = win_r;
  assign bus.move_err     = err_r;

endmodule
